// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter.
// Holds the FSM state encoding, the default bus widths and the ack-select codes.
package mem_arb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_DRAIN_I = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ACK_NONE = 2'd0,
    ACK_I    = 2'd1,
    ACK_D    = 2'd2
  } ack_sel_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Watchdog counter for the memory arbiter, present only in ARB_TIMEOUT_EN builds.
// Cleared on every grant, counts stalled cycles and saturates at TIMEOUT-1 (hit).
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == CW'(TIMEOUT - 1));

  // next count: clear wins over count; hold once the terminal value is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Optional watchdog abort is compiled in when ARB_TIMEOUT_EN is defined.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no transaction; data request wins over fetch
//  ST_BUSY_I  | fetch in flight; handoff to data on its ack
//  ST_BUSY_D  | load/store in flight; handoff to fetch on its ack
//  ST_DRAIN_I | killed fetch still in flight; its ack is swallowed
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ack,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  ack_sel_t          ack_sel;
  logic              gnt_d, gnt_i;
  logic              abort;
  logic              tmo_hit;
  logic              busy;
  logic [XLEN-1:0]   rdata_src;

  assign busy = (state_q != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(gnt_d | gnt_i),
    .en (busy & ~mem_ack),
    .hit(tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // next-state, grant and ack selection; everything idles while rst is low
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ack_sel = ACK_NONE;
    gnt_d   = 1'b0;
    gnt_i   = 1'b0;
    abort   = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (d_req) begin
            gnt_d = 1'b1;
          end else if (if_req && !if_kill) begin
            gnt_i = 1'b1;
          end
        end
        ST_BUSY_D: begin
          if (mem_ack) begin
            ack_sel = ACK_D;
            if (if_req && !if_kill) gnt_i = 1'b1;
            else state_d = ST_IDLE;
          end else if (tmo_hit) begin
            ack_sel = ACK_D;
            abort   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BUSY_I: begin
          if (mem_ack) begin
            if (!if_kill) begin
              ack_sel = ACK_I;
              if (d_req) gnt_d = 1'b1;
              else state_d = ST_IDLE;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tmo_hit) begin
            // a fetch killed in the abort cycle gets no ack
            if (!if_kill) ack_sel = ACK_I;
            abort   = 1'b1;
            state_d = ST_IDLE;
          end else if (if_kill) begin
            state_d = ST_DRAIN_I;
          end
        end
        ST_DRAIN_I: begin
          if (mem_ack) begin
            state_d = ST_IDLE;
          end else if (tmo_hit) begin
            abort   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (gnt_d) begin
        state_d = ST_BUSY_D;
        addr_d  = d_addr;
        wdata_d = d_wdata;
        we_d    = d_we;
      end else if (gnt_i) begin
        state_d = ST_BUSY_I;
        addr_d  = if_addr;
        wdata_d = '0;
        we_d    = 1'b0;
      end
    end
  end

  // state and latched memory command registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign rdata_src = abort ? '0 : mem_rdata;

  assign mem_req   = rst & busy & ~abort;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack    = (ack_sel == ACK_I);
  assign d_ack     = (ack_sel == ACK_D);
  assign if_rdata  = if_ack ? rdata_src : '0;
  assign d_rdata   = d_ack  ? rdata_src : '0;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  assign bus_err   = abort;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed protocol scenarios followed by a randomized
// phase against a port-level reference (expected memory image per port).
// The ARB_TIMEOUT_EN build additionally exercises the watchdog abort.
module tb_mem_port_arbiter;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_kill, if_ack;
  logic [ADDR_W-1:0] if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req, d_we, d_ack;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata, d_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic              stall_if, stall_mem, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // initial memory content: a fixed scramble of the address
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] exp_d   [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_d.exists(a) ? exp_d[a] : init_word(a);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit in_flight;
    int lat;
    bit if_done, d_done;
    int age_if, age_d;

    rst = 1'b0; if_req = 1'b1; if_addr = '0; if_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;

    // reset: outputs quiet even with a request and a stray ack present
    step(); step(); mid();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    step(); rst = 1'b1; if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mid();
    chk("rst_rel_mem_req", mem_req, 0);

    // 1: simple fetch, ack two cycles after mem_req
    step(); if_req = 1'b1; if_addr = 32'h100; mid();
    chk("t1_grant_latency", mem_req, 0);
    chk("t1_stall_if", stall_if, 1);
    step(); mid();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    step(); mid();
    chk("t1_no_early_ack", if_ack, 0);
    step(); mem_ack = 1'b1; mem_rdata = 32'h00500093; mid();
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'h00500093);
    chk("t1_stall_if_clr", stall_if, 0);
    step(); mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; mid();
    chk("t1_ack_pulse", if_ack, 0);
    chk("t1_idle", mem_req, 0);
    chk("t1_rdata_zero", if_rdata, 0);

    // 2: simultaneous requests, data (store) first then handoff to fetch
    step();
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    mid();
    chk("t2_stall_mem", stall_mem, 1);
    step(); mid();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 32'h2000);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step(); mem_ack = 1'b1; mid();
    chk("t2_d_ack", d_ack, 1);
    chk("t2_if_ack", if_ack, 0);
    chk("t2_stall_mem_clr", stall_mem, 0);
    chk("t2_stall_if", stall_if, 1);
    step(); mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0; mid();
    chk("t2_handoff_req", mem_req, 1);
    chk("t2_handoff_addr", mem_addr, 32'h300);
    chk("t2_handoff_we", mem_we, 0);
    step(); mem_ack = 1'b1; mem_rdata = 32'h00000013; mid();
    chk("t2_if_ack", if_ack, 1);
    chk("t2_if_rdata", if_rdata, 32'h00000013);
    step(); mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; mid();
    chk("t2_idle", mem_req, 0);

    // 3: kill during fetch -> drain, then new fetch at 0x200
    step(); if_req = 1'b1; if_addr = 32'h180; mid();
    step(); if_kill = 1'b1; if_addr = 32'h200; mid();
    chk("t3_busy_req", mem_req, 1);
    chk("t3_busy_addr", mem_addr, 32'h180);
    step(); if_kill = 1'b0; mid();
    chk("t3_drain_req", mem_req, 1);
    chk("t3_drain_addr", mem_addr, 32'h180);
    chk("t3_drain_stall", stall_if, 1);
    step(); mid();
    step(); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; mid();
    chk("t3_drain_no_ack", if_ack, 0);
    chk("t3_drain_rdata", if_rdata, 0);
    step(); mem_ack = 1'b0; mem_rdata = '0; mid();
    chk("t3_idle_after_drain", mem_req, 0);
    step(); mid();
    chk("t3_new_req", mem_req, 1);
    chk("t3_new_addr", mem_addr, 32'h200);
    step(); mem_ack = 1'b1; mem_rdata = 32'h00A00113; mid();
    chk("t3_new_ack", if_ack, 1);
    chk("t3_new_rdata", if_rdata, 32'h00A00113);
    step(); mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; mid();

    // 3b: kill in the same cycle as the fetch ack
    step(); if_req = 1'b1; if_addr = 32'h240; mid();
    step(); mid();
    chk("t3b_req", mem_req, 1);
    step(); mem_ack = 1'b1; if_kill = 1'b1; if_addr = 32'h280; mem_rdata = 32'h11111111; mid();
    chk("t3b_kill_ack", if_ack, 0);
    step(); mem_ack = 1'b0; if_kill = 1'b0; mem_rdata = '0; mid();
    chk("t3b_idle", mem_req, 0);
    step(); mid();
    chk("t3b_new_addr", mem_addr, 32'h280);
    step(); mem_ack = 1'b1; mem_rdata = 32'h22222222; mid();
    chk("t3b_ack", if_ack, 1);
    chk("t3b_rdata", if_rdata, 32'h22222222);
    step(); mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; mid();

    // 4: reset in the middle of a load, stale ack afterwards
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mid();
    step(); mid();
    chk("t4_busy_addr", mem_addr, 32'h40);
    step(); rst = 1'b0; mid();
    chk("t4_rst_req", mem_req, 0);
    chk("t4_rst_ack", d_ack, 0);
    step(); rst = 1'b1; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33333333; mid();
    chk("t4_stale_ack", d_ack, 0);
    chk("t4_stale_rdata", d_rdata, 0);
    chk("t4_idle_req", mem_req, 0);
    chk("t4_addr_cleared", mem_addr, 0);
    step(); mem_ack = 1'b0; mem_rdata = '0; mid();
    chk("t4_still_idle", mem_req, 0);

    // 6: back-to-back loads with a pending fetch: grants D, I, D
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h400; mid();
    step(); mid();
    chk("t6_g1_addr", mem_addr, 32'h10);
    step(); mem_ack = 1'b1; mem_rdata = 32'h44444444; mid();
    chk("t6_d1_ack", d_ack, 1);
    chk("t6_d1_rdata", d_rdata, 32'h44444444);
    step(); mem_ack = 1'b0; mem_rdata = '0; d_addr = 32'h14; mid();
    chk("t6_g2_addr", mem_addr, 32'h400);
    chk("t6_g2_we", mem_we, 0);
    chk("t6_stall_mem", stall_mem, 1);
    step(); mem_ack = 1'b1; mem_rdata = 32'h55555555; mid();
    chk("t6_i_ack", if_ack, 1);
    chk("t6_i_rdata", if_rdata, 32'h55555555);
    step(); mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; mid();
    chk("t6_g3_req", mem_req, 1);
    chk("t6_g3_addr", mem_addr, 32'h14);
    chk("t6_stall_if_clr", stall_if, 0);
    step(); mem_ack = 1'b1; mem_rdata = 32'h66666666; mid();
    chk("t6_d2_ack", d_ack, 1);
    chk("t6_d2_rdata", d_rdata, 32'h66666666);
    step(); mem_ack = 1'b0; mem_rdata = '0; d_req = 1'b0; mid();
    chk("t6_idle", mem_req, 0);

    // 5: load that never gets a memory ack
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mid();
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < TIMEOUT; c++) begin
      step(); mem_rdata = 32'h77777777; mid();
      if (c < TIMEOUT - 1) begin
        chk("t5_wait_ack", d_ack, 0);
        chk("t5_wait_err", bus_err, 0);
        chk("t5_wait_req", mem_req, 1);
      end else begin
        chk("t5_abort_ack", d_ack, 1);
        chk("t5_abort_rdata", d_rdata, 0);
        chk("t5_abort_err", bus_err, 1);
        chk("t5_abort_req", mem_req, 0);
      end
    end
    step(); d_req = 1'b0; mem_rdata = '0; mid();
    chk("t5_err_pulse", bus_err, 0);
    chk("t5_idle", mem_req, 0);
`else
    for (int c = 0; c < 24; c++) begin
      step(); mid();
      chk("t5_wait_ack", d_ack, 0);
      chk("t5_wait_err", bus_err, 0);
      chk("t5_wait_req", mem_req, 1);
    end
    step(); mem_ack = 1'b1; mem_rdata = 32'h77777777; mid();
    chk("t5_late_ack", d_ack, 1);
    chk("t5_late_rdata", d_rdata, 32'h77777777);
    step(); mem_ack = 1'b0; mem_rdata = '0; d_req = 1'b0; mid();
`endif

    // randomized traffic with a responding memory and occasional flushes
    in_flight = 1'b0; lat = 0;
    if_done = 1'b0; d_done = 1'b0; age_if = 0; age_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (mem_ack) begin
        mem_ack = 1'b0; mem_rdata = '0; in_flight = 1'b0;
        if (mem_req) begin in_flight = 1'b1; lat = int'($urandom_range(0, 2)); end
      end else if (!in_flight) begin
        if (mem_req) begin in_flight = 1'b1; lat = int'($urandom_range(0, 2)); end
      end else if (lat == 0) begin
        mem_ack = 1'b1;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata = mem_rd(mem_addr);
      end else begin
        lat--;
      end

      if_kill = 1'b0;
      if (if_req && !if_done && $urandom_range(0, 15) == 0) begin
        if_kill = 1'b1;
        if_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
        age_if = 0;
      end else if (!if_req || if_done) begin
        if_done = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          if_req = 1'b1;
          if_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
          age_if = 0;
        end else begin
          if_req = 1'b0;
        end
      end
      if (!d_req || d_done) begin
        d_done = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = 32'h2000 + ($urandom_range(0, 15) << 2);
          d_wdata = $urandom;
          age_d = 0;
        end else begin
          d_req = 1'b0;
        end
      end

      mid();
      chk("rnd_stall_if", stall_if, if_req & ~if_ack);
      chk("rnd_stall_mem", stall_mem, d_req & ~d_ack);
      if (if_kill) chk("rnd_kill_no_ack", if_ack, 0);
      if (!if_req) chk("rnd_if_spurious", if_ack, 0);
      if (!d_req) chk("rnd_d_spurious", d_ack, 0);
      if (if_ack && if_req) begin
        chk("rnd_if_rdata", if_rdata, init_word(if_addr));
        if_done = 1'b1;
      end
      if (d_ack && d_req) begin
        if (d_we) exp_d[d_addr] = d_wdata;
        else chk("rnd_d_rdata", d_rdata, exp_rd(d_addr));
        d_done = 1'b1;
      end
      if (if_req && !if_done) age_if++;
      if (d_req && !d_done) age_d++;
      if (age_if > 64) begin
        checks++; errors++;
        $error("FAIL rnd_if_bound observed=%0d cycles expected<=64", age_if);
        age_if = 0; if_done = 1'b1;
      end
      if (age_d > 64) begin
        checks++; errors++;
        $error("FAIL rnd_d_bound observed=%0d cycles expected<=64", age_d);
        age_d = 0; d_done = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
